// File: rtl/data_mem_hs.sv
// Byte-addressable data memory with sub-word load/store, misalignment detection
// and a req/ready/response handshake with LATENCY wait states before commit.
module data_mem_hs #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [2:0]        load_type_i,
  input  logic [1:0]        store_type_i,
  output logic              ready_o,
  output logic              rsp_valid_o,
  output logic [31:0]       rd_data_o,
  output logic              misalign_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic             r_we;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [2:0]       r_lt;
  logic [1:0]       r_st;

  logic [7:0]       r_mem [DEPTH];

  logic             w_accept, w_commit;
  logic             w_c_we;
  logic [IDX_W-1:0] w_c_idx, w_base;
  logic [31:0]      w_c_wdata;
  logic [2:0]       w_c_lt;
  logic [1:0]       w_c_st;
  logic [1:0]       w_off;
  logic             w_half, w_word, w_mis;
  logic [3:0]       w_be;
  logic [7:0]       w_lane_wd [4];
  logic [7:0]       w_rbyte [4];
  logic [7:0]       w_sel_byte;
  logic [15:0]      w_sel_half;
  logic [31:0]      w_load_data;

  generate
    if (ADDR_W > IDX_W) begin : g_alias
      logic w_unused_addr;
      assign w_unused_addr = ^addr_i[ADDR_W-1:IDX_W];
    end
  endgenerate

  assign ready_o  = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept = req_i && ready_o;
  assign w_commit = (LATENCY == 0) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With no wait states the access commits on its accept edge, straight from the inputs.
  assign w_c_we    = (LATENCY == 0) ? we_i                 : r_we;
  assign w_c_idx   = (LATENCY == 0) ? addr_i[IDX_W-1:0]    : r_idx;
  assign w_c_wdata = (LATENCY == 0) ? wr_data_i            : r_wdata;
  assign w_c_lt    = (LATENCY == 0) ? load_type_i          : r_lt;
  assign w_c_st    = (LATENCY == 0) ? store_type_i         : r_st;

  assign w_off  = w_c_idx[1:0];
  assign w_base = w_c_idx & ~IDX_W'(3);
  assign w_half = w_c_we ? (w_c_st == 2'b01) : (w_c_lt[1:0] == 2'b01);
  assign w_word = w_c_we ? (w_c_st == 2'b10) : w_c_lt[1];
  assign w_mis  = (w_half && w_off[0]) || (w_word && (w_off != 2'b00));

  // Lanes of the word containing the access; aligned accesses never leave it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_rbyte[gi]   = r_mem[w_base | IDX_W'(gi)];
      assign w_lane_wd[gi] = (w_c_st == 2'b10) ? w_c_wdata[8*gi +: 8] :
                             (w_c_st == 2'b01) ? w_c_wdata[8*(gi%2) +: 8] :
                                                 w_c_wdata[7:0];
      assign w_be[gi] = w_c_we && !w_mis &&
                        ((w_c_st == 2'b10) ||
                         ((w_c_st == 2'b01) && (w_off[1] == gi[1])) ||
                         ((w_c_st == 2'b00) && (w_off == 2'(gi))));
    end
  endgenerate

  assign w_sel_byte = w_rbyte[w_off];
  assign w_sel_half = w_off[1] ? {w_rbyte[3], w_rbyte[2]} : {w_rbyte[1], w_rbyte[0]};

  always_comb begin
    w_load_data = '0;
    if (!w_c_we && !w_mis) begin
      if (w_word)
        w_load_data = {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
      else if (w_half)
        w_load_data = {{16{!w_c_lt[2] && w_sel_half[15]}}, w_sel_half};
      else
        w_load_data = {{24{!w_c_lt[2] && w_sel_byte[7]}}, w_sel_byte};
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_state_next = (LATENCY == 0) ? S_RESP : S_WAIT;
          w_cnt_next   = CNT_INIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_next = S_RESP;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      rsp_valid_o <= 1'b0;
      rd_data_o   <= 32'd0;
      misalign_o  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      rsp_valid_o <= w_commit;
      rd_data_o   <= w_commit ? w_load_data : 32'd0;
      misalign_o  <= w_commit && w_mis;
    end
    if (w_accept) begin
      r_we    <= we_i;
      r_idx   <= addr_i[IDX_W-1:0];
      r_wdata <= wr_data_i;
      r_lt    <= load_type_i;
      r_st    <= store_type_i;
    end
  end

  // Memory is deliberately left out of reset; a reset edge only blocks the commit.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_base | IDX_W'(k)] <= w_lane_wd[k];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs: directed scenarios plus random accesses
// checked against a byte-array reference model.
module tb_data_mem_hs;
  localparam int AW    = 10;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          clk = 1'b0, rst_n = 1'b0, req_i = 1'b0, we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [31:0]   wr_data_i = '0;
  logic [2:0]    load_type_i = '0;
  logic [1:0]    store_type_i = 2'b11;
  logic          ready_o, rsp_valid_o, misalign_o;
  logic [31:0]   rd_data_o;

  int tests = 0;
  int fails = 0;
  logic [7:0] model_mem [DEPTH];

  data_mem_hs #(.ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wr_data_i(wr_data_i), .load_type_i(load_type_i), .store_type_i(store_type_i),
    .ready_o(ready_o), .rsp_valid_o(rsp_valid_o), .rd_data_o(rd_data_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // Reference: access size from the type code, misaligned when index % size != 0.
  task automatic model_do(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [2:0] lt, input logic [1:0] st,
                          output logic [31:0] rd, output logic mis);
    int size;
    int idx;
    idx = int'(addr) % DEPTH;
    if (we) size = (st == 2'd3) ? 0 : (1 << st);
    else    size = (lt == 3'd0 || lt == 3'd4) ? 1 : (lt == 3'd1 || lt == 3'd5) ? 2 : 4;
    mis = (size > 1) && ((idx % size) != 0);
    rd  = 32'd0;
    if (!mis) begin
      if (we) begin
        for (int i = 0; i < size; i++) model_mem[idx + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd = rd | (32'(model_mem[idx + i]) << (8 * i));
        if (lt == 3'd0 && rd[7])  rd = rd | 32'hFFFF_FF00;
        if (lt == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
      end
    end
  endtask

  task automatic access(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [2:0] lt, input logic [1:0] st,
                        output logic [31:0] rd, output logic mis,
                        output logic [31:0] exp_rd, output logic exp_mis);
    int k;
    int lat;
    bit got;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; wr_data_i = wd;
    load_type_i = lt; store_type_i = st;
    k = 0;
    while (!ready_o && k < 20) begin @(negedge clk); k++; end
    tests++;
    if (!ready_o) begin fails++; $display("FAIL ready_timeout: ready_o=%0b required 1", ready_o); end
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'($urandom); addr_i = AW'($urandom); wr_data_i = $urandom;
    load_type_i = 3'($urandom); store_type_i = 2'($urandom);
    model_do(we, addr, wd, lt, st, exp_rd, exp_mis);
    rd = '0; mis = 1'b0; lat = 0; got = 0;
    for (int j = 1; j <= 20 && !got; j++) begin
      @(negedge clk);
      if (rsp_valid_o) begin got = 1; lat = j; rd = rd_data_o; mis = misalign_o; end
    end
    tests++;
    if (lat != LAT + 1) begin
      fails++; $display("FAIL rsp_latency: got %0d edges required %0d", lat, LAT + 1);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid_o !== 1'b0 || rd_data_o !== 32'd0 || misalign_o !== 1'b0) begin
      fails++;
      $display("FAIL rsp_pulse_width: valid=%0b data=%h mis=%0b required 0/0/0",
               rsp_valid_o, rd_data_o, misalign_o);
    end
    $display("[TB] %s addr=%h wd=%h lt=%0d st=%0d -> rd=%h mis=%0b lat=%0d",
             we ? "ST" : "LD", addr, wd, lt, st, rd, mis, lat);
  endtask

  task automatic test_clear();
    logic [31:0] rd, erd;
    logic mis, emis;
    for (int w = 0; w < DEPTH / 4; w++) access(1'b1, AW'(w * 4), 32'd0, 3'd0, 2'd2, rd, mis, erd, emis);
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd;
    logic mis, emis;
    @(negedge clk);
    rst_n = 1'b0; req_i = 1'b1; we_i = 1'b1; addr_i = '0; wr_data_i = 32'hFFFF_FFFF;
    store_type_i = 2'd2;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; req_i = 1'b0;
    @(negedge clk);
    tests++;
    if (ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rd_data_o !== 32'd0 || misalign_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ready=%0b valid=%0b data=%h mis=%0b required 1/0/0/0",
               ready_o, rsp_valid_o, rd_data_o, misalign_o);
    end
    access(1'b0, 10'h000, 32'd0, 3'd2, 2'd3, rd, mis, erd, emis);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_no_write: got %h required 00000000", rd); end
  endtask

  task automatic test_subword();
    logic [31:0] rd, erd;
    logic mis, emis;
    logic [AW-1:0] a [4];
    logic [2:0]    t [4];
    logic [31:0]   e [4];
    a = '{10'h013, 10'h013, 10'h012, 10'h012};
    t = '{3'd0, 3'd4, 3'd1, 3'd5};
    e = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_DEAD};
    access(1'b1, 10'h010, 32'hDEAD_BEEF, 3'd0, 2'd2, rd, mis, erd, emis);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, a[i], 32'd0, t[i], 2'd3, rd, mis, erd, emis);
      tests++;
      if (rd !== e[i] || mis !== 1'b0) begin
        fails++; $display("FAIL subword_%0d: got %h/%0b required %h/0", i, rd, mis, e[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd;
    logic mis, emis;
    access(1'b1, 10'h011, 32'h0000_1234, 3'd0, 2'd1, rd, mis, erd, emis);
    tests++;
    if (rd !== 32'd0 || mis !== 1'b1) begin
      fails++; $display("FAIL misalign_sh: got %h/%0b required 00000000/1", rd, mis);
    end
    access(1'b0, 10'h010, 32'd0, 3'd2, 2'd3, rd, mis, erd, emis);
    tests++;
    if (rd !== 32'hDEAD_BEEF || mis !== 1'b0) begin
      fails++; $display("FAIL misalign_nowrite: got %h/%0b required deadbeef/0", rd, mis);
    end
    access(1'b0, 10'h012, 32'd0, 3'd2, 2'd3, rd, mis, erd, emis);
    tests++;
    if (rd !== 32'd0 || mis !== 1'b1) begin
      fails++; $display("FAIL misalign_lw: got %h/%0b required 00000000/1", rd, mis);
    end
  endtask

  task automatic test_back_to_back();
    int acc_edge [2];
    int n_acc;
    int n_rsp;
    bit w_acc;
    logic [31:0] rd2, erd;
    logic emis;
    n_acc = 0; n_rsp = 0; rd2 = 32'hX;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 10'h020; wr_data_i = 32'h0000_007F; store_type_i = 2'd0;
    for (int e = 0; e < 12; e++) begin
      if (rsp_valid_o) begin
        n_rsp++;
        tests++;
        if (ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready_in_resp: got %0b required 1", ready_o); end
        if (n_rsp == 2) rd2 = rd_data_o;
      end
      w_acc = req_i && ready_o;
      @(posedge clk);
      if (w_acc && n_acc < 2) begin acc_edge[n_acc] = e; n_acc++; end
      #1;
      if (w_acc && n_acc == 1) begin
        model_do(1'b1, 10'h020, 32'h0000_007F, 3'd0, 2'd0, erd, emis);
        we_i = 1'b0; addr_i = 10'h020; load_type_i = 3'd2;
      end else if (w_acc) begin
        model_do(1'b0, 10'h020, 32'd0, 3'd2, 2'd3, erd, emis);
        req_i = 1'b0;
      end
      @(negedge clk);
    end
    tests++;
    if (n_acc != 2 || acc_edge[1] - acc_edge[0] != LAT + 1) begin
      fails++; $display("FAIL b2b_accept_gap: accepts=%0d gap=%0d required 2/%0d",
                        n_acc, acc_edge[1] - acc_edge[0], LAT + 1);
    end
    tests++;
    if (n_rsp != 2 || rd2 !== 32'h0000_007F) begin
      fails++; $display("FAIL b2b_load: rsps=%0d data=%h required 2/0000007f", n_rsp, rd2);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd, erd;
    logic mis, emis;
    access(1'b1, 10'h110, 32'hCAFE_F00D, 3'd0, 2'd2, rd, mis, erd, emis);
    access(1'b0, 10'h010, 32'd0, 3'd2, 2'd3, rd, mis, erd, emis);
    tests++;
    if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL alias: got %h required cafef00d", rd); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd, erd;
    logic mis, emis;
    bit seen;
    seen = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 10'h040; wr_data_i = 32'h1122_3344; store_type_i = 2'd2;
    @(posedge clk);
    #1; req_i = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid_o) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL mid_reset_rsp: got pulse required none"); end
    access(1'b0, 10'h040, 32'd0, 3'd2, 2'd3, rd, mis, erd, emis);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_reset_nowrite: got %h required 00000000", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd;
    logic mis, emis;
    for (int i = 0; i < 80; i++) begin
      access(1'($urandom), AW'($urandom), $urandom, 3'($urandom), 2'($urandom), rd, mis, erd, emis);
      tests++;
      if (rd !== erd || mis !== emis) begin
        fails++; $display("FAIL random_%0d: got %h/%0b required %h/%0b", i, rd, mis, erd, emis);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    test_clear();
    test_reset();
    test_subword();
    test_misalign();
    test_back_to_back();
    test_alias();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
